// File: rtl/life_if.sv
// life_if: control, seed and status bundle between a controller and life_engine
interface life_if #(parameter int ROWS = 16, COLS = 16, CNT_W = 16, PER_W = 8);
   logic load, start, stop, step;
   logic [ROWS*COLS-1:0] seed, grid;
   logic [PER_W-1:0] period;
   logic [CNT_W-1:0] gen_count;
   logic running, evolve_valid, stable;
   modport master(output load, seed, start, stop, step, period,
                  input grid, gen_count, running, evolve_valid, stable);
   modport slave(input load, seed, start, stop, step, period,
                 output grid, gen_count, running, evolve_valid, stable);
endinterface

// File: rtl/life_engine.sv
// life_engine: registered B3/S23 Game of Life grid with step and periodic run modes; LIFE_TORUS_EN wraps edges toroidally
module life_engine #(
   parameter int ROWS = 16,
   parameter int COLS = 16,
   parameter int CNT_W = 16,
   parameter int PER_W = 8
) (
   input logic clk,
   input logic reset,
   life_if.slave bus
);
   localparam int N = ROWS * COLS;
   localparam int PC = COLS + 2;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state;
   logic [N-1:0] grid, nxt;
   logic [(ROWS+2)*PC-1:0] pad;
   logic [CNT_W-1:0] gen_count;
   logic [PER_W-1:0] cnt;
   logic evolve_valid, stable, upd;
   logic [3:0] n;
   // One-cell halo around the grid so every cell sees a full 3x3 window
   always_comb begin
      pad = '0;
      for (int r = -1; r <= ROWS; r++)
         for (int c = -1; c <= COLS; c++)
`ifdef LIFE_TORUS_EN
            pad[(r+1)*PC+c+1] = grid[((r+ROWS)%ROWS)*COLS+(c+COLS)%COLS];
`else
            if (r >= 0 && r < ROWS && c >= 0 && c < COLS) pad[(r+1)*PC+c+1] = grid[r*COLS+c];
`endif
   end
   always_comb begin
      nxt = '0;
      n = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            n = '0;
            for (int dr = 0; dr < 3; dr++)
               for (int dc = 0; dc < 3; dc++)
                  if (dr != 1 || dc != 1) n = n + 4'(pad[(r+dr)*PC+c+dc]);
            nxt[r*COLS+c] = n == 4'd3 || (n == 4'd2 && grid[r*COLS+c]);
         end
   end
   assign upd = state == IDLE ? bus.step : cnt == '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         grid <= '0;
         gen_count <= '0;
         cnt <= '0;
         evolve_valid <= 1'b0;
         stable <= 1'b0;
      end else if (bus.load) begin
         state <= IDLE;
         grid <= bus.seed;
         gen_count <= '0;
         stable <= 1'b0;
         evolve_valid <= 1'b0;
      end else if (bus.stop) begin
         state <= IDLE;
         evolve_valid <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         state <= RUN;
         cnt <= bus.period;
         evolve_valid <= 1'b0;
      end else begin
         evolve_valid <= upd;
         if (state == RUN) cnt <= cnt == '0 ? bus.period : cnt - PER_W'(1);
         if (upd) begin
            grid <= nxt;
            gen_count <= gen_count + CNT_W'(1);
            stable <= nxt == grid;
            if (nxt == grid) state <= IDLE;
         end
      end
   end
   assign bus.grid = grid;
   assign bus.gen_count = gen_count;
   assign bus.running = state == RUN;
   assign bus.evolve_valid = evolve_valid;
   assign bus.stable = stable;
endmodule

// File: tb/tb_life_engine.sv
// tb_life_engine: randomized scoreboard bench for life_engine against a 2-D neighbour-count reference model
module tb_life_engine;
   localparam int R = 16, C = 16, CW = 2, PW = 8;
   typedef logic [R*C-1:0] g_t;
   typedef struct {g_t grid; logic [CW-1:0] gen; logic stable; int due;} exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int passed = 0, total = 0, cyc = 0;
   exp_t q[$];
   exp_t want;
   g_t m_grid = '0;
   logic [CW-1:0] m_gen = '0;

   life_if #(.ROWS(R), .COLS(C), .CNT_W(CW), .PER_W(PW)) bus();
   life_engine #(.ROWS(R), .COLS(C), .CNT_W(CW), .PER_W(PW)) dut(.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input g_t act, input g_t exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   function automatic g_t life_next(input g_t g);
      g_t res;
      int live, rr, cc;
      res = '0;
      for (int r = 0; r < R; r++)
         for (int c = 0; c < C; c++) begin
            live = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++) begin
                  rr = r + dr;
                  cc = c + dc;
                  if (dr == 0 && dc == 0) continue;
`ifdef LIFE_TORUS_EN
                  rr = (rr + R) % R;
                  cc = (cc + C) % C;
`else
                  if (rr < 0 || rr >= R || cc < 0 || cc >= C) continue;
`endif
                  live += int'(g[rr*C+cc]);
               end
            res[r*C+c] = live == 3 || (live == 2 && g[r*C+c]);
         end
      return res;
   endfunction

   function automatic g_t rand_grid();
      g_t g;
      for (int i = 0; i < R*C; i++) g[i] = $urandom_range(0, 3) == 0;
      return g;
   endfunction

   // Monitor: every evolve_valid pulse must match the oldest predicted update, in its cycle
   always @(negedge clk) begin
      if (bus.evolve_valid === 1'b1) begin
         if (q.size() == 0) chk("evolve_valid_unexpected", g_t'(bus.evolve_valid), g_t'(0));
         else begin
            want = q.pop_front();
            chk("evolve_cycle", g_t'(cyc), g_t'(want.due));
            chk("grid", bus.grid, want.grid);
            chk("gen_count", g_t'(bus.gen_count), g_t'(want.gen));
            chk("stable", g_t'(bus.stable), g_t'(want.stable));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_update(output bit st);
      g_t nx;
      nx = life_next(m_grid);
      st = nx == m_grid;
      m_gen++;
      m_grid = nx;
      q.push_back('{nx, m_gen, st, cyc + 1});
   endtask

   task automatic do_load(input g_t s, input bit with_start);
      bus.seed = s;
      bus.load = 1'b1;
      bus.start = with_start;
      tick();
      bus.load = 1'b0;
      bus.start = 1'b0;
      m_grid = s;
      m_gen = '0;
      chk("load_grid", bus.grid, s);
      chk("load_running", g_t'(bus.running), g_t'(0));
   endtask

   task automatic do_step(input bit with_stop);
      bit st;
      if (!with_stop) expect_update(st);
      bus.step = 1'b1;
      bus.stop = with_stop;
      tick();
      bus.step = 1'b0;
      bus.stop = 1'b0;
      chk("step_running", g_t'(bus.running), g_t'(0));
   endtask

   // Next update falls period+1 edges after the start edge or the previous update
   task automatic run(input int p, input int ncyc, input int stop_at, input bit jitter);
      bit on, st;
      int next_upd;
      bus.period = PW'(p);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      on = 1'b1;
      next_upd = p + 1;
      chk("start_running", g_t'(bus.running), g_t'(1));
      for (int i = 1; i <= ncyc; i++) begin
         bus.stop = i == stop_at;
         bus.start = jitter && on && $urandom_range(0, 1) == 1;
         if (jitter) bus.period = PW'($urandom_range(0, 3));
         if (on && i == stop_at) on = 1'b0;
         else if (on && i == next_upd) begin
            expect_update(st);
            on = !st;
            next_upd = i + int'(bus.period) + 1;
         end
         tick();
         bus.stop = 1'b0;
         bus.start = 1'b0;
         chk("running", g_t'(bus.running), g_t'(on));
      end
   endtask

   initial begin
      g_t g, exp;
      int n;
      bus.load = 1'b0;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.step = 1'b0;
      bus.seed = '0;
      bus.period = '0;
      tick();
      tick();
      chk("reset_grid", bus.grid, '0);
      chk("reset_gen", g_t'(bus.gen_count), g_t'(0));
      chk("reset_running", g_t'(bus.running), g_t'(0));
      chk("reset_evolve", g_t'(bus.evolve_valid), g_t'(0));
      chk("reset_stable", g_t'(bus.stable), g_t'(0));
      reset = 1'b0;
      // Blinker: vertical, back, and the 2-bit counter wrapping on the fourth step
      g = '0;
      g[5*C +: C] = 16'h0070;
      do_load(g, 1'b0);
      do_step(1'b0);
      exp = '0;
      exp[4*C +: C] = 16'h0020;
      exp[5*C +: C] = 16'h0020;
      exp[6*C +: C] = 16'h0020;
      chk("blinker_vertical", bus.grid, exp);
      tick();
      chk("evolve_single_pulse", g_t'(bus.evolve_valid), g_t'(0));
      do_step(1'b0);
      chk("blinker_back", bus.grid, g);
      do_step(1'b0);
      do_step(1'b0);
      chk("gen_wrap", g_t'(bus.gen_count), g_t'(0));
      do_step(1'b1);
      chk("stop_blocks_step", bus.grid, g);
      // Block still life halts run mode on its first update
      g = '0;
      g[7*C +: C] = 16'h0018;
      g[8*C +: C] = 16'h0018;
      do_load(g, 1'b0);
      run(0, 3, 0, 1'b0);
      chk("block_stable", g_t'(bus.stable), g_t'(1));
      chk("block_gen", g_t'(bus.gen_count), g_t'(1));
      // Period 3 cadence, stop between updates, stop on a due update
      g = '0;
      g[5*C +: C] = 16'h0070;
      do_load(g, 1'b0);
      run(3, 10, 10, 1'b0);
      run(3, 8, 6, 1'b0);
      run(1, 6, 4, 1'b0);
      // Corner blinker
      g = '0;
      g[0 +: C] = 16'h8003;
      do_load(g, 1'b0);
      do_step(1'b0);
      exp = '0;
`ifdef LIFE_TORUS_EN
      exp[0 +: C] = 16'h0001;
      exp[C +: C] = 16'h0001;
      exp[15*C +: C] = 16'h0001;
`endif
      chk("corner_blinker", bus.grid, exp);
      // Load beats start
      do_load(rand_grid(), 1'b1);
      // Reset mid-run
      g = '0;
      g[5*C +: C] = 16'h0070;
      do_load(g, 1'b0);
      run(0, 3, 0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_grid = '0;
      m_gen = '0;
      chk("midrun_reset_grid", bus.grid, '0);
      chk("midrun_reset_gen", g_t'(bus.gen_count), g_t'(0));
      chk("midrun_reset_running", g_t'(bus.running), g_t'(0));
      chk("midrun_reset_evolve", g_t'(bus.evolve_valid), g_t'(0));
      chk("midrun_reset_stable", g_t'(bus.stable), g_t'(0));
      // Random mix of loads, steps, runs and idle cycles
      repeat (40) begin
         case ($urandom_range(0, 3))
            0: do_load(rand_grid(), 1'($urandom_range(0, 1)));
            1: do_step($urandom_range(0, 4) == 0);
            2: begin
               n = $urandom_range(4, 20);
               run($urandom_range(0, 3), n, $urandom_range(1, n), 1'b1);
            end
            default: begin
               tick();
               chk("idle_running", g_t'(bus.running), g_t'(0));
               chk("idle_grid", bus.grid, m_grid);
            end
         endcase
      end
      tick();
      chk("final_grid", bus.grid, m_grid);
      chk("scoreboard_drained", g_t'(q.size()), g_t'(0));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/life_engine.md
# life_engine

Registered, parametrised Conway's Game of Life engine that holds a ROWS×COLS grid and advances it one generation per step or on a programmable cadence in run mode. It replaces the purely combinational 16×16 grid evolve datapath, which needed its bench to feed back `grid_evolve` by hand. It is the generation core beneath the display and seed-loading logic.

## Interface
- ROWS, default 16, grid rows (≥3)
- COLS, default 16, grid columns (≥3)
- CNT_W, default 16, generation counter width
- PER_W, default 8, run-mode period width

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- load  in  1  capture `seed` into the grid
- seed  in  ROWS*COLS  initial grid
- start  in  1  enter run mode
- stop  in  1  leave run mode
- step  in  1  single generation (idle only)
- period  in  PER_W  idle cycles between run-mode generations
- grid  out  ROWS*COLS  current generation
- gen_count  out  CNT_W  generations since last load
- running  out  1  high in RUN state
- evolve_valid  out  1  one-cycle pulse in the cycle after each grid update
- stable  out  1  last update produced a grid identical to its predecessor

## Operation
- Cell (r,c) is bit r*COLS+c; row 0 is grid[COLS-1:0]; bit c=0 is the LSB of its row.
- Rule B3/S23: a live cell with 2 or 3 live neighbours survives; a dead cell with exactly 3 is born; every other cell is dead. Eight-neighbour Moore neighbourhood. Neighbour count is 4 bits, with no saturation.
- Edges: cells outside the grid are dead (see Configuration).
- FSM states: IDLE and RUN.
  - IDLE→RUN on start.
  - RUN→IDLE on stop, on load, or on an update that sets stable.
- Input priority per edge: reset > load > stop > start/step.
  - load: grid←seed, gen_count←0, stable←0, state←IDLE.
  - step in IDLE: one update. step in RUN is ignored.
  - start in RUN is ignored, and the period counter is not reloaded.
- Period counter:
  - Loaded with `period` on the IDLE→RUN edge.
  - Each RUN edge: if counter==0, update and reload `period`; otherwise decrement.
  - `period` is sampled only at load points; changes mid-count take effect at the next reload.
- Update:
  - grid←next(grid).
  - gen_count←gen_count+1, wrapping modulo 2^CNT_W.
  - stable←(next==grid).
  - evolve_valid pulses.
- A stable update in RUN returns the engine to IDLE on the same edge.

## Timing
- Reset values: grid=0, gen_count=0, running=0, evolve_valid=0, stable=0, counter=0, state IDLE.
- Latency:
  - load → grid valid one cycle later.
  - step → updated grid and evolve_valid one cycle later.
- start sampled at edge t:
  - running=1 after t.
  - Updates occur at edges t+1+P, t+2+2P, …, where P=period.
  - P=0 gives one generation per cycle.
- stop at an edge where counter==0: no update, running=0 after that edge.
- Simultaneous load and start: load wins; engine stays IDLE.
- Simultaneous step and start in IDLE: start wins; no immediate update.
- reset mid-RUN clears all state on that edge; no update occurs.
- next(grid) is combinational from the grid register. There is no pipeline; throughput is one generation per cycle.

## Configuration
- LIFE_TORUS_EN
  - Defined: toroidal wrap. Row ROWS-1 neighbours row 0, column COLS-1 neighbours column 0, and corners wrap diagonally.
  - Undefined: dead-boundary behaviour above.
- No other behaviour changes with the macro.

## Test plan
- Blinker, 16×16, grid5=16'h0070, step → grid4=grid5=grid6=16'h0020, all other rows 0, gen_count=1, evolve_valid one cycle, stable=0. Second step → original grid, gen_count=2.
- Block, 16'h0018 in rows 7 and 8, start with period=0 → one update at t+1, stable=1, running=0 after t+1, gen_count=1.
- period=3, blinker, start at t → evolve_valid at t+5 and t+9 (the cycles after update edges t+4 and t+8), none between. stop at t+6 → no further updates, running=0.
- Corner blinker: grid0=16'h8003.
  - Without LIFE_TORUS_EN, step → grid all zero.
  - With LIFE_TORUS_EN, step → grid15=grid0=grid1=16'h0001.
- Priority and reset:
  - load and start in the same cycle → grid=seed, running=0.
  - reset asserted mid-RUN → all outputs 0 next cycle.
  - gen_count with CNT_W=2 wraps 3→0 on the fourth blinker step.
